ifft4_out_serializer: RTL and testbench
=======================================

// Module: ifft4_out_serializer
// PURPOSE
//  Downstream stage of the 4-point IFFT. Captures each parallel 4-sample complex result
//  frame (qualified by the IFFT valid) into a 2-frame buffer and streams it out one complex
//  sample per beat, index 0..3, over a valid/ready handshake. The IFFT has no backpressure;
//  this block absorbs short stalls and drops whole frames when full.
// PARAMETERS
//  DATA_WIDTH  8  IFFT input width; every sample here is SW = DATA_WIDTH+2 bits, signed
//  POINTS      4  samples per frame; fixed at 4 (index width 2)
// PORTS
//  clk                 in   1       clock
//  rst_n               in   1       asynchronous reset, active low
//  in_valid            in   1       frame strobe from IFFT valid; each high cycle = one frame
//  in0..in3_real/imag  in   SW      parallel frame, signed
//  out_real/out_imag   out  SW      current serial sample, signed
//  out_index           out  2       sample index within frame (0..3)
//  out_last            out  1       high with index 3
//  out_valid           out  1       sample available
//  out_ready           in   1       consumer accepts when out_valid && out_ready
//  overflow            out  1       one-cycle pulse when a frame is dropped
// BEHAVIOUR
//  - Reset: buffer count 0, wr/rd pointers 0, index 0; out_valid, out_last, overflow, out_index,
//    out_real, out_imag all 0. Reset mid-frame discards all buffered frames.
//  - Buffer: 2 frame slots, wr_ptr/rd_ptr 1 bit each, count 0..2.
//  - Write: in_valid at edge N with count<2 stores frame; out_valid visible after edge N
//    (first beat at N+1 when buffer was empty). Latency in_valid -> out_valid = 1 cycle.
//  - Read: out_valid = (count!=0). Outputs are mux of slot[rd_ptr] at out_index; values stay
//    stable while out_valid && !out_ready. Beat: index++; beat at index 3 pops slot, rd_ptr
//    toggles, index -> 0. out_last = out_valid && index==3.
//  - Full (count==2) + in_valid: if the same cycle pops (beat at index 3), the write is accepted
//    (count stays 2); otherwise frame dropped, buffer untouched, overflow=1 for that cycle.
//  - Simultaneous write and pop with count 1: count stays 1, pointers both advance.
//  - Continuous in_valid every cycle with out_ready=1: 1 frame per 4 cycles accepted, rest
//    dropped; no corruption of the frame being streamed.
//  - out_real/out_imag are 0 whenever out_valid=0.
// CONFIGURATION
//  IFFT4_SER_DROP_CNT_EN defined: adds output drop_cnt [15:0]; increments on every overflow
//  pulse, saturates at 16'hFFFF, reset to 0. Undefined: port and counter absent; overflow
//  pulse unchanged.
// STRUCTURE
//  Shared package/include ifft4_pkg: POINTS=4, IDX_W=2, SAMPLE_W(DATA_WIDTH)=DATA_WIDTH+2,
//  frame-slot record layout {real[4], imag[4]}. One sub-module: ifft4_frame_buf (2-slot frame
//  store, pointers, count, full/empty); serializer index/handshake logic stays in the top.
// TESTING
//  1 Single frame re=(1,2,3,4), im=(-1,-2,-3,-4), out_ready=1 -> 4 beats next cycles,
//    index 0..3, out_last on beat 4, then out_valid=0.
//  2 out_ready=0 for 10 cycles after frame -> out_valid=1, index 0, data stable; release ->
//    4 beats in order.
//  3 Three frames A,B,C on consecutive cycles, out_ready=0 -> A,B kept, C dropped, overflow
//    pulses once; drain yields A then B (8 beats).
//  4 Full buffer, new frame same cycle as A's index-3 beat -> accepted, no overflow; output
//    A,B,new.
//  5 Reset asserted mid-stream at index 2 -> all outputs 0 immediately; after release
//    out_valid=0 until next in_valid.
//  6 IFFT4_SER_DROP_CNT_EN: 70000 dropped frames -> drop_cnt == 16'hFFFF; without macro,
//    port absent, test 3 still passes.

Source files
------------

// File: rtl/ifft4_pkg.sv
// Shared constants and frame-slot layout helpers for the 4-point IFFT output path.
// Slot layout: {real[3..0], imag[3..0]}, with lane i at bit offset i*SW inside each half.
package ifft4_pkg;
  localparam int POINTS = 4;
  localparam int IDX_W  = 2;
  localparam int SLOTS  = 2;

  function automatic int sample_w(input int data_width);
    return data_width + 2;
  endfunction

  function automatic int frame_w(input int sw);
    return 2 * POINTS * sw;
  endfunction

  function automatic int real_lsb(input int sw, input int lane);
    return (POINTS + lane) * sw;
  endfunction

  function automatic int imag_lsb(input int sw, input int lane);
    return lane * sw;
  endfunction
endpackage

// File: rtl/ifft4_frame_buf.sv
// Two-slot frame store with 1-bit write/read pointers and a 0..2 occupancy count.
// A write while full is accepted only when the same cycle pops; otherwise it is reported as dropped.
module ifft4_frame_buf
  import ifft4_pkg::*;
#(
  parameter int FRAME_W = 80
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [FRAME_W-1:0] wr_data,
  input  logic               pop,
  output logic [FRAME_W-1:0] rd_data,
  output logic               empty,
  output logic               full,
  output logic               drop
);
  logic [FRAME_W-1:0] slot [SLOTS];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               do_pop;
  logic               wr_accept;

  assign empty     = (count == 2'd0);
  assign full      = (count == 2'd2);
  assign do_pop    = pop && !empty;
  assign wr_accept = wr_en && (!full || do_pop);
  assign drop      = wr_en && !wr_accept;
  assign rd_data   = slot[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= ~wr_ptr;
      if (do_pop)    rd_ptr <= ~rd_ptr;
      case ({wr_accept, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Slot payload needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (wr_accept) slot[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/ifft4_out_serializer.sv
// Buffers parallel 4-sample IFFT frames and streams them one complex sample per beat.
// Optional feature macro: IFFT4_SER_DROP_CNT_EN adds a saturating drop_cnt output.
module ifft4_out_serializer
  import ifft4_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int SW         = DATA_WIDTH + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [SW-1:0]    in0_real,
  input  logic [SW-1:0]    in0_imag,
  input  logic [SW-1:0]    in1_real,
  input  logic [SW-1:0]    in1_imag,
  input  logic [SW-1:0]    in2_real,
  input  logic [SW-1:0]    in2_imag,
  input  logic [SW-1:0]    in3_real,
  input  logic [SW-1:0]    in3_imag,
  output logic [SW-1:0]    out_real,
  output logic [SW-1:0]    out_imag,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
`ifdef IFFT4_SER_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);
  localparam int FW = frame_w(SW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POINTS - 1);

  logic [FW-1:0] wr_frame;
  logic [FW-1:0] rd_frame;
  logic          empty;
  logic          full;
  logic          beat;
  logic          pop;
  logic [SW-1:0] re_lane [POINTS];
  logic [SW-1:0] im_lane [POINTS];

  assign wr_frame = {in3_real, in2_real, in1_real, in0_real,
                     in3_imag, in2_imag, in1_imag, in0_imag};

  ifft4_frame_buf #(.FRAME_W(FW)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid),
    .wr_data (wr_frame),
    .pop     (pop),
    .rd_data (rd_frame),
    .empty   (empty),
    .full    (full),
    .drop    (overflow)
  );

  for (genvar i = 0; i < POINTS; i++) begin : g_lane
    assign re_lane[i] = rd_frame[real_lsb(SW, i) +: SW];
    assign im_lane[i] = rd_frame[imag_lsb(SW, i) +: SW];
  end

  // Handshake: a beat happens when out_valid && out_ready at a rising edge;
  // while out_valid && !out_ready the sample, index and last flag hold steady.
  assign out_valid = !empty;
  assign beat      = out_valid && out_ready;
  assign pop       = beat && (out_index == LAST_IDX);
  assign out_last  = out_valid && (out_index == LAST_IDX);
  assign out_real  = out_valid ? re_lane[out_index] : '0;
  assign out_imag  = out_valid ? im_lane[out_index] : '0;

  // The 2-bit index wraps 3 -> 0 on the beat that pops the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_index <= '0;
    end else if (beat) begin
      out_index <= out_index + 1'b1;
    end
  end

`ifdef IFFT4_SER_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 16'd0;
    end else if (overflow && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  logic unused_full;
  assign unused_full = full;
endmodule

// File: tb/tb_ifft4_out_serializer.sv
// Directed bench for ifft4_out_serializer: inputs change on the falling edge,
// outputs are checked 1 time unit later, before the next rising edge.
module tb_ifft4_out_serializer;
  localparam int DW = 8;
  localparam int SW = DW + 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [SW-1:0] in0_real, in0_imag, in1_real, in1_imag;
  logic [SW-1:0] in2_real, in2_imag, in3_real, in3_imag;
  logic [SW-1:0] out_real, out_imag;
  logic [1:0]    out_index;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          overflow;
`ifdef IFFT4_SER_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int vectors;
  int miscompares;

  ifft4_out_serializer #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in0_real  (in0_real),
    .in0_imag  (in0_imag),
    .in1_real  (in1_real),
    .in1_imag  (in1_imag),
    .in2_real  (in2_real),
    .in2_imag  (in2_imag),
    .in3_real  (in3_real),
    .in3_imag  (in3_imag),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_index (out_index),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
`ifdef IFFT4_SER_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  function automatic logic [SW-1:0] sv(input int v);
    return v[SW-1:0];
  endfunction

  function automatic logic [15:0] z(input logic [SW-1:0] x);
    return 16'(x);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame with base b: real[i] = b*(i+1), imag[i] = -b*(i+1).
  task automatic load_frame(input int b);
    in0_real = sv(b);     in0_imag = sv(-b);
    in1_real = sv(2 * b); in1_imag = sv(-2 * b);
    in2_real = sv(3 * b); in2_imag = sv(-3 * b);
    in3_real = sv(4 * b); in3_imag = sv(-4 * b);
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic check_beat(input string tag, input int b, input int k);
    #1;
    chk({tag, "_valid"}, 16'(out_valid), 16'd1);
    chk({tag, "_index"}, 16'(out_index), 16'(k));
    chk({tag, "_real"},  z(out_real), z(sv(b * (k + 1))));
    chk({tag, "_imag"},  z(out_imag), z(sv(-b * (k + 1))));
    chk({tag, "_last"},  16'(out_last), 16'(k == 3));
  endtask

  task automatic check_idle(input string tag);
    #1;
    chk({tag, "_valid"}, 16'(out_valid), 16'd0);
    chk({tag, "_real"},  z(out_real), 16'd0);
    chk({tag, "_imag"},  z(out_imag), 16'd0);
    chk({tag, "_last"},  16'(out_last), 16'd0);
  endtask

  task automatic stream_frame(input string tag, input int b);
    for (int k = 0; k < 4; k++) begin
      check_beat(tag, b, k);
      step();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    load_frame(0);

    // reset state
    step();
    step();
    check_idle("reset");
    chk("reset_index", 16'(out_index), 16'd0);
    chk("reset_overflow", 16'(overflow), 16'd0);
`ifdef IFFT4_SER_DROP_CNT_EN
    chk("reset_drop_cnt", drop_cnt, 16'd0);
`endif
    rst_n = 1'b1;
    step();

    // 1: single frame, consumer always ready
    load_frame(1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 chk("t1_pre_valid", 16'(out_valid), 16'd0);
    step();
    in_valid = 1'b0;
    stream_frame("t1", 1);
    check_idle("t1_after");

    // 2: consumer stalled for 10 cycles, then released
    out_ready = 1'b0;
    load_frame(10);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check_beat("t2_stall", 10, 0);
      step();
    end
    out_ready = 1'b1;
    stream_frame("t2", 10);
    check_idle("t2_after");

    // 3: three back-to-back frames while stalled; third is dropped
    out_ready = 1'b0;
    load_frame(1);
    in_valid = 1'b1;
    #1 chk("t3_ovf_a", 16'(overflow), 16'd0);
    step();
    load_frame(10);
    #1 chk("t3_ovf_b", 16'(overflow), 16'd0);
    step();
    load_frame(100);
    #1 chk("t3_ovf_c", 16'(overflow), 16'd1);
    step();
    in_valid = 1'b0;
    #1 chk("t3_ovf_after", 16'(overflow), 16'd0);
`ifdef IFFT4_SER_DROP_CNT_EN
    chk("t3_drop_cnt", drop_cnt, 16'd1);
`endif
    out_ready = 1'b1;
    stream_frame("t3_a", 1);
    stream_frame("t3_b", 10);
    check_idle("t3_after");

    // 4: full buffer, new frame arrives on the index-3 beat of the head frame
    out_ready = 1'b0;
    load_frame(1);
    in_valid = 1'b1;
    step();
    load_frame(10);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_beat("t4_a", 1, k);
      step();
    end
    load_frame(-50);
    in_valid = 1'b1;
    check_beat("t4_a", 1, 3);
    chk("t4_ovf", 16'(overflow), 16'd0);
    step();
    in_valid = 1'b0;
    stream_frame("t4_b", 10);
    stream_frame("t4_d", -50);
    check_idle("t4_after");

    // 5: reset asserted mid-frame at index 2
    load_frame(1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check_beat("t5", 1, k);
      step();
    end
    check_beat("t5", 1, 2);
    rst_n = 1'b0;
    check_idle("t5_rst");
    chk("t5_rst_index", 16'(out_index), 16'd0);
    step();
    rst_n = 1'b1;
    step();
    check_idle("t5_post1");
    step();
    check_idle("t5_post2");

`ifdef IFFT4_SER_DROP_CNT_EN
    // 6: saturate the drop counter
    chk("t6_drop_cnt_rst", drop_cnt, 16'd0);
    out_ready = 1'b0;
    load_frame(3);
    in_valid = 1'b1;
    step();
    step();
    for (int c = 0; c < 70000; c++) step();
    in_valid = 1'b0;
    #1 chk("t6_drop_cnt_sat", drop_cnt, 16'hFFFF);
    check_beat("t6_head", 3, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
